// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader / run controller.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RELEASE,
    ST_RUN,
    ST_HALTED,
    ST_TIMEOUT
  } loader_state_t;

  // jal x0,0 : the core parks on itself when the program is finished
  localparam logic [31:0] HALT_JAL_SELF = 32'h0000006f;

endpackage

// File: rtl/prog_loader_if.sv
// Program stream handshake plus the instruction-memory write port it drives.
interface prog_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader_run_watchdog.sv
// Run-cycle counter with clear, enable, freeze and a terminal-count flag.
module run_watchdog #(
  parameter int MAX_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        freeze,
  output logic [31:0] count,
  output logic        tc
);
  localparam logic [31:0] LAST = 32'(MAX_CYCLES - 1);
  localparam logic [31:0] ONE  = 32'd1;

  logic [31:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && !freeze) begin
      count_reg <= count_reg + ONE;
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == LAST);
endmodule

// File: rtl/prog_loader.sv
// Streams a program image into instruction memory, then releases the core and
// supervises its run until a halt instruction or a watchdog timeout.
module prog_loader
  import loader_pkg::*;
#(
  parameter int                 DATA_W     = 32,
  parameter int                 ADDR_W     = 10,
  parameter int                 MAX_CYCLES = 1024,
  parameter logic [DATA_W-1:0]  HALT_INSN  = DATA_W'(HALT_JAL_SELF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  prog_loader_if.slave      bus,
  input  logic [DATA_W-1:0] instr,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       cycle_count
);
  localparam int unsigned     DEPTH_I = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH   = DEPTH_I[ADDR_W:0];
  localparam logic [ADDR_W:0] LEN_ONE = 1;
  localparam logic [ADDR_W-1:0] CNT_ONE = 1;

  loader_state_t     state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg;
  logic [ADDR_W:0]   len_reg;
  logic [ADDR_W:0]   len_clamped;
  logic              start_ok, accept, last_word, halt_seen;
  logic              wd_clr, wd_en, wd_freeze, wd_tc;
  logic              core_reset_reg, core_reset_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              timeout_reg, timeout_next;

  assign len_clamped = (load_len > DEPTH) ? DEPTH : load_len;
  assign start_ok    = load_start && ((state_reg == ST_IDLE) ||
                                      (state_reg == ST_HALTED) ||
                                      (state_reg == ST_TIMEOUT));
  assign accept      = (state_reg == ST_LOAD) && bus.s_valid;
  assign last_word   = accept && ({1'b0, cnt_reg} == (len_reg - LEN_ONE));
  assign halt_seen   = (instr == HALT_INSN);

  // State register together with the load counter and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      len_reg        <= '0;
      core_reset_reg <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      core_reset_reg <= core_reset_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      timeout_reg    <= timeout_next;
      if (start_ok) begin
        cnt_reg <= '0;
        len_reg <= len_clamped;
      end else if (accept) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
        if (load_start) begin
          state_next = (load_len == '0) ? ST_RELEASE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (last_word) begin
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: state_next = ST_RUN;
      ST_RUN: begin
        // a halt on the watchdog's last cycle still counts as a clean finish
        if (halt_seen) begin
          state_next = ST_HALTED;
        end else if (wd_tc) begin
          state_next = ST_TIMEOUT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.s_ready    = (state_reg == ST_LOAD);
    bus.imem_we    = accept;
    bus.imem_addr  = accept ? cnt_reg : '0;
    bus.imem_wdata = accept ? bus.s_data : '0;

    core_reset_next = !((state_next == ST_RUN) || (state_next == ST_HALTED));
    busy_next       = (state_next == ST_LOAD) || (state_next == ST_RELEASE) ||
                      (state_next == ST_RUN);

    done_next    = done_reg;
    timeout_next = timeout_reg;
    if (state_next == ST_RELEASE) begin
      done_next    = 1'b0;
      timeout_next = 1'b0;
    end else if (state_next == ST_HALTED) begin
      done_next = 1'b1;
    end else if (state_next == ST_TIMEOUT) begin
      timeout_next = 1'b1;
    end

    // the timeout edge must not advance the count past MAX_CYCLES-1
    wd_clr    = (state_next == ST_RELEASE);
    wd_en     = (state_reg == ST_RUN);
    wd_freeze = (state_next == ST_TIMEOUT);
  end

  run_watchdog #(
    .MAX_CYCLES(MAX_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (reset),
    .clr   (wd_clr),
    .en    (wd_en),
    .freeze(wd_freeze),
    .count (cycle_count),
    .tc    (wd_tc)
  );

  assign core_reset = core_reset_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign timeout    = timeout_reg;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a tiny behavioural core (addi/jal-self) on its memory.
module tb_prog_loader;
  import loader_pkg::*;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        exp_we;
    logic [9:0]  exp_addr;
  } vec_t;

  localparam logic [31:0] ADDI5  = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] ADDI1  = 32'h00108093;  // addi x1,x1,1
  localparam logic [31:0] HALT   = 32'h0000006f;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic [10:0] load_len;
  logic [31:0] instr;
  logic        core_reset, busy, done, timeout;
  logic [31:0] cycle_count;

  prog_loader_if #(.DATA_W(32), .ADDR_W(10)) bus ();

  prog_loader #(
    .DATA_W(32), .ADDR_W(10), .MAX_CYCLES(16), .HALT_INSN(HALT)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .load_start (load_start),
    .load_len   (load_len),
    .bus        (bus),
    .instr      (instr),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory and core model
  logic [31:0] tb_mem [0:1023];
  logic        mem_clr;
  logic [9:0]  pc;
  logic [31:0] x1;
  logic [31:0] imm;
  logic [31:0] src;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= '0;
    end else if (bus.imem_we) begin
      tb_mem[bus.imem_addr] <= bus.imem_wdata;
    end
  end

  assign instr = tb_mem[pc];
  assign imm   = {{20{instr[31]}}, instr[31:20]};
  assign src   = (instr[19:15] == 5'd1) ? x1 : 32'd0;

  always @(posedge clk) begin
    if (core_reset) begin
      pc <= '0;
      x1 <= '0;
    end else if (instr[6:0] == 7'h13 && instr[14:12] == 3'd0) begin
      if (instr[11:7] == 5'd1) x1 <= src + imm;
      pc <= pc + 10'd1;
    end else if (instr != HALT) begin
      pc <= pc + 10'd1;
    end
  end

  int   errors = 0;
  int   checks = 0;
  vec_t vtab [0:63];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setv(input int i, input logic v, input logic [31:0] d,
                      input logic we, input logic [9:0] a);
    vtab[i].valid    = v;
    vtab[i].data     = d;
    vtab[i].exp_we   = we;
    vtab[i].exp_addr = a;
  endtask

  task automatic do_start(input logic [10:0] len);
    load_start = 1'b1;
    load_len   = len;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.s_valid = vtab[i].valid;
      bus.s_data  = vtab[i].data;
      #1;
      $display("vec %0d valid=%0d data=%08h we=%0d addr=%0d", i, vtab[i].valid,
               vtab[i].data, bus.imem_we, bus.imem_addr);
      chk("s_ready_load", {31'd0, bus.s_ready}, 32'd1);
      chk("imem_we", {31'd0, bus.imem_we}, {31'd0, vtab[i].exp_we});
      if (vtab[i].exp_we) begin
        chk("imem_addr", {22'd0, bus.imem_addr}, {22'd0, vtab[i].exp_addr});
        chk("imem_wdata", bus.imem_wdata, vtab[i].data);
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
  endtask

  // Entered at the negedge of the RELEASE cycle; leaves at the first RUN cycle
  task automatic check_release();
    #1;
    chk("rel_core_reset", {31'd0, core_reset}, 32'd1);
    chk("rel_busy", {31'd0, busy}, 32'd1);
    chk("rel_s_ready", {31'd0, bus.s_ready}, 32'd0);
    @(negedge clk);
    chk("run0_core_reset", {31'd0, core_reset}, 32'd0);
    chk("run0_cycle_count", cycle_count, 32'd0);
    chk("run0_done", {31'd0, done}, 32'd0);
    chk("run0_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_flag(input int sel, input int budget);
    int n;
    n = 0;
    while ((((sel == 0) ? done : timeout) !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (((sel == 0) ? done : timeout) !== 1'b1) begin
      errors++;
      $display("FAIL wait_%s: flag still low after %0d cycles, required high",
               (sel == 0) ? "done" : "timeout", budget);
    end
  endtask

  task automatic clear_mem();
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    load_start  = 1'b0;
    load_len    = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    mem_clr     = 1'b1;

    // A: full-rate load of the 3-word program
    setv(0, 1, ADDI5, 1, 0);
    setv(1, 1, ADDI1, 1, 1);
    setv(2, 1, HALT,  1, 2);
    // B: same program under valid pattern 1,0,0,1,0,1
    setv(3, 1, ADDI5, 1, 0);
    setv(4, 0, 32'hdeadbeef, 0, 0);
    setv(5, 0, 32'hdeadbeef, 0, 0);
    setv(6, 1, ADDI1, 1, 1);
    setv(7, 0, 32'hdeadbeef, 0, 0);
    setv(8, 1, HALT,  1, 2);
    // D: halt lands exactly on the watchdog's last cycle
    for (int i = 0; i < 15; i++) setv(9 + i, 1, ADDI1, 1, 10'(i));
    setv(24, 1, HALT, 1, 15);
    // E: no halt, watchdog must fire
    for (int i = 0; i < 4; i++) setv(25 + i, 1, ADDI1, 1, 10'(i));
    // F: reload after a reset that interrupted the load
    setv(29, 1, ADDI5, 1, 0);
    setv(30, 1, ADDI1, 1, 1);
    setv(31, 1, ADDI1, 1, 2);
    setv(32, 1, ADDI1, 1, 3);
    setv(33, 1, HALT,  1, 4);
    setv(34, 1, ADDI5, 1, 0);
    setv(35, 1, ADDI1, 1, 1);

    repeat (3) @(negedge clk);
    chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
    chk("rst_imem_addr", {22'd0, bus.imem_addr}, 32'd0);
    chk("rst_imem_wdata", bus.imem_wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    mem_clr = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);

    // A
    do_start(11'd3);
    apply_vecs(0, 2);
    check_release();
    wait_flag(0, 40);
    chk("A_cycle_count", cycle_count, 32'd3);
    chk("A_x1", x1, 32'd6);
    chk("A_timeout", {31'd0, timeout}, 32'd0);
    repeat (2) @(negedge clk);
    chk("A_count_frozen", cycle_count, 32'd3);
    chk("A_core_released", {31'd0, core_reset}, 32'd0);

    // B
    clear_mem();
    do_start(11'd3);
    apply_vecs(3, 8);
    check_release();
    wait_flag(0, 40);
    chk("B_cycle_count", cycle_count, 32'd3);
    chk("B_x1", x1, 32'd6);

    // C: rerun the resident image, load_start in RUN must be ignored
    do_start(11'd0);
    check_release();
    load_start = 1'b1;
    load_len   = 11'd2;
    @(negedge clk);
    load_start = 1'b0;
    chk("C_ignore_s_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("C_ignore_core_reset", {31'd0, core_reset}, 32'd0);
    chk("C_ignore_count", cycle_count, 32'd1);
    wait_flag(0, 40);
    chk("C_cycle_count", cycle_count, 32'd3);
    chk("C_x1", x1, 32'd6);

    // D
    clear_mem();
    do_start(11'd16);
    apply_vecs(9, 24);
    check_release();
    wait_flag(0, 40);
    chk("D_cycle_count", cycle_count, 32'd16);
    chk("D_x1", x1, 32'd15);
    @(negedge clk);
    chk("D_timeout", {31'd0, timeout}, 32'd0);

    // E
    clear_mem();
    do_start(11'd4);
    apply_vecs(25, 28);
    check_release();
    wait_flag(1, 40);
    chk("E_done", {31'd0, done}, 32'd0);
    chk("E_cycle_count", cycle_count, 32'd15);
    chk("E_core_reset", {31'd0, core_reset}, 32'd1);
    chk("E_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("E_count_frozen", cycle_count, 32'd15);

    // F: async reset after 2 of 5 words
    do_start(11'd5);
    apply_vecs(34, 35);
    bus.s_valid = 1'b1;
    bus.s_data  = ADDI1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("F_core_reset", {31'd0, core_reset}, 32'd1);
    chk("F_s_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("F_imem_we", {31'd0, bus.imem_we}, 32'd0);
    chk("F_busy", {31'd0, busy}, 32'd0);
    chk("F_timeout", {31'd0, timeout}, 32'd0);
    chk("F_cycle_count", cycle_count, 32'd0);
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(11'd5);
    apply_vecs(29, 33);
    check_release();
    wait_flag(0, 40);
    chk("F_final_count", cycle_count, 32'd5);
    chk("F_x1", x1, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end
endmodule
